// File: rtl/midi_note_if.sv
// Byte-in / note-out bundle between the UART receiver, the note parser and the tone generator.
interface midi_note_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [6:0] note;
    logic [6:0] volume;
    logic       gate;
    logic       note_strobe;
    logic       sync_err;

    modport master (
        output rx_valid, rx_data,
        input  note, volume, gate, note_strobe, sync_err
    );

    modport slave (
        input  rx_valid, rx_data,
        output note, volume, gate, note_strobe, sync_err
    );
endinterface

// File: rtl/midi_note_parser.sv
// Monophonic MIDI Note On/Off/All-Notes-Off decoder feeding the tone generator.
// Optional macro MIDI_CHANNEL_FILTER_EN: only messages on CHANNEL affect the note outputs.
module midi_note_parser #(
    parameter logic [6:0] DEFAULT_NOTE = 7'd69,
    parameter logic [3:0] CHANNEL      = 4'd0
) (
    input  logic      clk,
    input  logic      reset,
    midi_note_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] status_reg, status_next;
    logic [6:0] d1_reg, d1_next;
    logic       silent_reg, silent_next;
    logic [6:0] note_reg, note_next;
    logic [6:0] velocity_reg, velocity_next;
    logic       gate_reg, gate_next;
    logic       strobe_reg, strobe_next;
    logic       sync_err_reg, sync_err_next;
    logic       chan_ok;

`ifdef MIDI_CHANNEL_FILTER_EN
    assign chan_ok = (status_reg[3:0] == CHANNEL);
`else
    logic unused_channel;
    assign unused_channel = ^CHANNEL;
    assign chan_ok        = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            status_reg   <= 8'h00;
            d1_reg       <= 7'd0;
            silent_reg   <= 1'b0;
            note_reg     <= DEFAULT_NOTE;
            velocity_reg <= 7'd0;
            gate_reg     <= 1'b0;
            strobe_reg   <= 1'b0;
            sync_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            status_reg   <= status_next;
            d1_reg       <= d1_next;
            silent_reg   <= silent_next;
            note_reg     <= note_next;
            velocity_reg <= velocity_next;
            gate_reg     <= gate_next;
            strobe_reg   <= strobe_next;
            sync_err_reg <= sync_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        status_next   = status_reg;
        d1_next       = d1_reg;
        silent_next   = silent_reg;
        note_next     = note_reg;
        velocity_next = velocity_reg;
        gate_next     = gate_reg;
        strobe_next   = 1'b0;
        sync_err_next = 1'b0;

        if (bus.rx_valid) begin
            if (bus.rx_data[7:3] == 5'b11111) begin
                // real-time bytes are transparent, even mid-message
            end else if (bus.rx_data[7:4] == 4'hF) begin
                state_next  = IDLE;
                status_next = 8'h00;
                silent_next = 1'b1;
            end else if (bus.rx_data[7]) begin
                sync_err_next = (state_reg == WAIT_D2);
                status_next   = bus.rx_data;
                silent_next   = 1'b0;
                state_next    = WAIT_D1;
            end else begin
                case (state_reg)
                    IDLE: sync_err_next = ~silent_reg;
                    WAIT_D1: begin
                        // program change / channel pressure carry a single data byte
                        if (status_reg[7:5] != 3'b110) begin
                            d1_next    = bus.rx_data[6:0];
                            state_next = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        state_next = WAIT_D1;
                        if (chan_ok) begin
                            case (status_reg[7:4])
                                4'h9, 4'h8: begin
                                    if (status_reg[4] && bus.rx_data[6:0] != 7'd0) begin
                                        note_next     = d1_reg;
                                        velocity_next = bus.rx_data[6:0];
                                        gate_next     = 1'b1;
                                        strobe_next   = 1'b1;
                                    end else if (gate_reg && d1_reg == note_reg) begin
                                        gate_next = 1'b0;
                                    end
                                end
                                4'hB: begin
                                    if (d1_reg == 7'd123) gate_next = 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    assign bus.note        = note_reg;
    assign bus.volume      = gate_reg ? velocity_reg : 7'd0;
    assign bus.gate        = gate_reg;
    assign bus.note_strobe = strobe_reg;
    assign bus.sync_err    = sync_err_reg;

endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench for midi_note_parser: a byte-level reference model predicts outputs per cycle.
module tb_midi_note_parser;
    localparam int CHANNEL = 0;

    logic clk = 1'b0;
    logic reset;
    midi_note_if bus ();

    midi_note_parser #(.DEFAULT_NOTE(7'd69), .CHANNEL(4'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    typedef struct {
        int note;
        int volume;
        int gate;
        int strobe;
        int serr;
    } exp_t;

    exp_t sb[$];
    int   stim[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    // reference model state: m_st < 0 means no running status
    int m_st, m_have_d1, m_d1, m_silent;
    int m_note, m_vel, m_gate, m_strobe, m_serr;

    task automatic check(input string tag, input int actual, input int expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic void model_reset();
        m_st = -1; m_have_d1 = 0; m_d1 = 0; m_silent = 0;
        m_note = 69; m_vel = 0; m_gate = 0; m_strobe = 0; m_serr = 0;
    endfunction

    function automatic void model_byte(input int b);
        int hi;
        bit ok;
        m_strobe = 0;
        m_serr   = 0;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            m_st = -1; m_have_d1 = 0; m_silent = 1;
        end else if (b >= 8'h80) begin
            m_serr = m_have_d1; m_st = b; m_have_d1 = 0; m_silent = 0;
        end else if (m_st < 0) begin
            m_serr = !m_silent;
        end else begin
            hi = m_st >> 4;
            if (hi == 4'hC || hi == 4'hD) return;
            if (!m_have_d1) begin
                m_d1 = b; m_have_d1 = 1;
                return;
            end
            m_have_d1 = 0;
`ifdef MIDI_CHANNEL_FILTER_EN
            ok = ((m_st & 15) == CHANNEL);
`else
            ok = 1'b1;
`endif
            if (!ok) return;
            if (hi == 9 && b != 0) begin
                m_note = m_d1; m_vel = b; m_gate = 1; m_strobe = 1;
            end else if (hi == 8 || hi == 9) begin
                if (m_gate && m_d1 == m_note) m_gate = 0;
            end else if (hi == 4'hB && m_d1 == 123) begin
                m_gate = 0;
            end
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.note = m_note; e.volume = m_gate ? m_vel : 0; e.gate = m_gate;
        e.strobe = m_strobe; e.serr = m_serr;
        sb.push_back(e);
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        check("note",        int'(bus.note),        e.note);
        check("volume",      int'(bus.volume),      e.volume);
        check("gate",        int'(bus.gate),        e.gate);
        check("note_strobe", int'(bus.note_strobe), e.strobe);
        check("sync_err",    int'(bus.sync_err),    e.serr);
    endtask

    // One clock: drive, predict, then sample 1 time unit after the edge.
    task automatic cycle(input bit valid, input int b);
        bus.rx_valid = valid;
        bus.rx_data  = 8'(b);
        if (reset) model_reset();
        else if (valid) model_byte(b);
        else begin m_strobe = 0; m_serr = 0; end
        push_expect();
        @(posedge clk);
        #1;
        compare_out();
        $display("cycle rst=%0b v=%0b byte=%02h -> note=%02h vol=%02h gate=%0b strobe=%0b serr=%0b",
                 reset, valid, b[7:0], bus.note, bus.volume, bus.gate, bus.note_strobe, bus.sync_err);
    endtask

    task automatic play();
        foreach (stim[i]) cycle(1'b1, stim[i]);
        cycle(1'b0, 0);
        stim.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b1, 8'h90);
        cycle(1'b1, 8'h3C);
        reset = 1'b0;
        cycle(1'b0, 0);
    endtask

    initial begin
        int r, b;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        @(posedge clk);
        #1;

        do_reset();
        repeat (3) cycle(1'b0, 0);

        stim = '{8'h90, 8'h3C, 8'h64}; play();
        stim = '{8'h3E, 8'h50, 8'h3C, 8'h00, 8'h3E, 8'h00}; play();

        do_reset();
        stim = '{8'h90, 8'h3C, 8'hF8, 8'h64}; play();
        do_reset();
        stim = '{8'h45}; play();

        do_reset();
        stim = '{8'h90, 8'h3C, 8'h80, 8'h3C, 8'h00}; play();
        stim = '{8'h90, 8'h30, 8'h40, 8'hB0, 8'h7B, 8'h00}; play();
        stim = '{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h56}; play();
        stim = '{8'hC0, 8'h05, 8'h06, 8'hE0, 8'h10, 8'h20}; play();

        do_reset();
        stim = '{8'h91, 8'h40, 8'h7F, 8'h90, 8'h40, 8'h7F, 8'h81, 8'h40, 8'h00}; play();

        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      b = $urandom_range(60, 63);
            else if (r < 33) b = 0;
            else if (r < 36) b = 123;
            else if (r < 45) b = $urandom_range(0, 127);
            else if (r < 50) b = $urandom_range(8'hF8, 8'hFF);
            else if (r < 53) b = $urandom_range(8'hF0, 8'hF7);
            else if (r < 68) b = 8'h90 | $urandom_range(0, 1);
            else if (r < 76) b = 8'h80 | $urandom_range(0, 1);
            else if (r < 81) b = 8'hB0 | $urandom_range(0, 1);
            else if (r < 85) b = 8'hC0 | $urandom_range(0, 1);
            else if (r < 88) b = 8'hE0;
            else b = -1;
            if (b < 0) cycle(1'b0, 0);
            else cycle(1'b1, b);
            if (i == 200) do_reset();
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
